// File: rtl/scottcpu_alu_seq_if.sv
// Request/response bundle between the CPU control unit and the multi-byte ALU sequencer.
// The control unit drives the master side; the sequencer sits on the slave side.
interface scottcpu_alu_seq_if #(
  parameter int NBYTES = 4
);
  logic                  START;
  logic [2:0]            OP;
  logic                  CIN;
  logic [8*NBYTES-1:0]   A_IN;
  logic [8*NBYTES-1:0]   B_IN;
  logic                  BUSY;
  logic                  DONE;
  logic [8*NBYTES-1:0]   RESULT;
  logic                  CF;
  logic                  ZF;
  logic                  EF;

  modport master (
    output START, OP, CIN, A_IN, B_IN,
    input  BUSY, DONE, RESULT, CF, ZF, EF
  );

  modport slave (
    input  START, OP, CIN, A_IN, B_IN,
    output BUSY, DONE, RESULT, CF, ZF, EF
  );
endinterface

// File: rtl/scottcpu_alu_seq.sv
// Multi-byte sequencer: streams wide operands one byte per cycle through the 8-bit
// scottcpu ALU, chaining carry between bytes and aggregating zero/equal flags.

module scottcpu_alu (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cfin,
  input  logic [2:0] op,
  output logic [7:0] result,
  output logic       cfout,
  output logic       zf,
  output logic       ef
);
  // Byte ALU: logic ops (3-7) never produce a carry.
  always_comb begin
    result = 8'h00;
    cfout  = 1'b0;
    case (op)
      3'd0: {cfout, result} = {1'b0, a} + {1'b0, b} + {8'h00, cfin};
      3'd1: begin
        result = {a[6:0], cfin};
        cfout  = a[7];
      end
      3'd2: begin
        result = {cfin, a[7:1]};
        cfout  = a[0];
      end
      3'd3: result = ~a;
      3'd4: result = a & b;
      3'd5: result = a | b;
      3'd6: result = a ^ b;
      3'd7: result = 8'h00;
      default: result = 8'h00;
    endcase
    zf = (result == 8'h00);
    ef = (a == b);
  end
endmodule

module scottcpu_alu_seq #(
  parameter int NBYTES = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  scottcpu_alu_seq_if.slave    bus
);
  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state_r;
  logic [2:0]      op_r;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic [W-1:0]    work_r;
  logic            carry_r;
  logic [IDXW-1:0] idx_r;
  logic            zacc_r;
  logic            eacc_r;

  logic            busy_r;
  logic            done_r;
  logic [W-1:0]    result_r;
  logic            cf_r;
  logic            zf_r;
  logic            ef_r;

  logic [IDXW-1:0] sel_s;
  logic [IDXW+2:0] shamt_s;
  logic [7:0]      a_byte_s;
  logic [7:0]      b_byte_s;
  logic [W-1:0]    work_next_s;
  logic [7:0]      alu_res_s;
  logic            alu_cf_s;
  logic            alu_zf_s;
  logic            alu_ef_s;

  // Byte selection: shr walks MSB-first so the carry travels downward.
  always_comb begin
    if (op_r == 3'd2) begin
      sel_s = LAST_IDX - idx_r;
    end else begin
      sel_s = idx_r;
    end
    shamt_s     = {sel_s, 3'b000};
    a_byte_s    = 8'(a_r >> shamt_s);
    b_byte_s    = 8'(b_r >> shamt_s);
    work_next_s = (work_r & ~(W'(8'hFF) << shamt_s)) | (W'(alu_res_s) << shamt_s);
  end

  scottcpu_alu u_alu (
    .a      (a_byte_s),
    .b      (b_byte_s),
    .cfin   (carry_r),
    .op     (op_r),
    .result (alu_res_s),
    .cfout  (alu_cf_s),
    .zf     (alu_zf_s),
    .ef     (alu_ef_s)
  );

  // Sequencer FSM; RESULT is only updated from the working register on completion.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r  <= ST_IDLE;
      op_r     <= 3'd0;
      a_r      <= '0;
      b_r      <= '0;
      work_r   <= '0;
      carry_r  <= 1'b0;
      idx_r    <= '0;
      zacc_r   <= 1'b0;
      eacc_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= '0;
      cf_r     <= 1'b0;
      zf_r     <= 1'b0;
      ef_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.START) begin
            op_r    <= bus.OP;
            a_r     <= bus.A_IN;
            b_r     <= bus.B_IN;
            carry_r <= bus.CIN;
            work_r  <= '0;
            idx_r   <= '0;
            zacc_r  <= 1'b1;
            eacc_r  <= 1'b1;
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          work_r  <= work_next_s;
          carry_r <= alu_cf_s;
          zacc_r  <= zacc_r & alu_zf_s;
          eacc_r  <= eacc_r & alu_ef_s;
          if (idx_r == LAST_IDX) begin
            idx_r    <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            result_r <= work_next_s;
            cf_r     <= alu_cf_s;
            zf_r     <= zacc_r & alu_zf_s;
            ef_r     <= eacc_r & alu_ef_s;
            state_r  <= ST_IDLE;
          end else begin
            idx_r <= idx_r + IDXW'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          idx_r   <= '0;
        end
      endcase
    end
  end

  assign bus.BUSY   = busy_r;
  assign bus.DONE   = done_r;
  assign bus.RESULT = result_r;
  assign bus.CF     = cf_r;
  assign bus.ZF     = zf_r;
  assign bus.EF     = ef_r;
endmodule
